// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle control unit
package mc_ctrl_pkg;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXE    = 3'd3;
  localparam logic [2:0] S_MEM_RD = 3'd4;
  localparam logic [2:0] S_MEM_WR = 3'd5;
  localparam logic [2:0] S_WB_ALU = 3'd6;
  localparam logic [2:0] S_WB_MEM = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC    = 2'b10;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    C_R_ALU, C_ORI, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [1:0]   ext_op;
    logic         alu_src;
    logic [2:0]   alu_ctr;
    logic [1:0]   reg_dst;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational op/funct decoder to instruction class and selects
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o.cls     = C_ILLEGAL;
    dec_o.ext_op  = EXT_ZERO;
    dec_o.alu_src = 1'b0;
    dec_o.alu_ctr = ALU_ADD;
    dec_o.reg_dst = RD_RT;
    case (op_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADDU || funct_i == FN_SUBU) begin
          dec_o.cls     = C_R_ALU;
          dec_o.reg_dst = RD_RD;
          dec_o.alu_ctr = (funct_i == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end
      end
      OP_ORI: begin
        dec_o.cls     = C_ORI;
        dec_o.alu_src = 1'b1;
        dec_o.alu_ctr = ALU_OR;
      end
      OP_LUI: begin
        dec_o.cls     = C_LUI;
        dec_o.ext_op  = EXT_LUI;
        dec_o.alu_src = 1'b1;
      end
      OP_LW, OP_SW: begin
        dec_o.cls     = (op_i == OP_LW) ? C_LOAD : C_STORE;
        dec_o.ext_op  = EXT_SIGN;
        dec_o.alu_src = 1'b1;
      end
      OP_BEQ: begin
        dec_o.cls     = C_BRANCH;
        dec_o.ext_op  = EXT_SIGN;
        dec_o.alu_ctr = ALU_SUB;
      end
      OP_J:    dec_o.cls = C_JUMP;
      OP_JAL: begin
        dec_o.cls     = C_JAL;
        dec_o.reg_dst = RD_RA;
      end
      default: dec_o.cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle control FSM: state register, sequencing and strobe gating
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] ext_op,
  output logic       alu_src,
  output logic [2:0] alu_ctr,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] npc_op,
  output logic       illegal
);

  logic [2:0] state_q, state_d;
  dec_t       dec;

  mc_ctrl_decode u_decode (
    .op_i    (op),
    .funct_i (funct),
    .dec_o   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    ext_op  = EXT_ZERO;
    alu_src = 1'b0;
    alu_ctr = ALU_ADD;
    reg_dst = RD_RT;
    wb_sel  = WB_ALU;
    npc_op  = NPC_PLUS4;
    illegal = 1'b0;

    // IR is stable from DECODE onward, so the decoded selects are simply held.
    if (state_q != S_INIT && state_q != S_FETCH) begin
      ext_op  = dec.ext_op;
      alu_src = dec.alu_src;
      alu_ctr = dec.alu_ctr;
      reg_dst = dec.reg_dst;
    end

    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (dec.cls)
          C_JUMP: begin
            pc_wr   = 1'b1;
            npc_op  = NPC_JUMP;
            state_d = S_FETCH;
          end
          C_JAL: begin
            pc_wr   = 1'b1;
            npc_op  = NPC_JUMP;
            reg_wr  = 1'b1;
            wb_sel  = WB_PC;
            state_d = S_FETCH;
          end
          C_ILLEGAL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (dec.cls)
          C_R_ALU, C_ORI, C_LUI: state_d = S_WB_ALU;
          C_LOAD:                state_d = S_MEM_RD;
          C_STORE:               state_d = S_MEM_WR;
          C_BRANCH: begin
            pc_wr   = zero;
            npc_op  = NPC_BRANCH;
            state_d = S_FETCH;
          end
          default:               state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: state_d = S_WB_MEM;
      S_MEM_WR: begin
        mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        reg_wr  = 1'b1;
        wb_sel  = WB_MEM;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized self-checking bench for mc_ctrl_fsm against a per-instruction cycle model
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, illegal;
  logic [1:0] ext_op, reg_dst, wb_sel, npc_op;
  logic [2:0] alu_ctr;

  int n_checks = 0;
  int n_fail = 0;

  mc_ctrl_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .funct   (funct),
    .zero    (zero),
    .pc_wr   (pc_wr),
    .ir_wr   (ir_wr),
    .reg_wr  (reg_wr),
    .mem_wr  (mem_wr),
    .ext_op  (ext_op),
    .alu_src (alu_src),
    .alu_ctr (alu_ctr),
    .reg_dst (reg_dst),
    .wb_sel  (wb_sel),
    .npc_op  (npc_op),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // {pc_wr, ir_wr, reg_wr, mem_wr, ext_op, alu_src, alu_ctr, reg_dst, wb_sel, npc_op, illegal}
  wire [16:0] obs = {pc_wr, ir_wr, reg_wr, mem_wr, ext_op, alu_src, alu_ctr,
                     reg_dst, wb_sel, npc_op, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_r(input logic [5:0] f);
    return f == 6'b100001 || f == 6'b100011;
  endfunction

  function automatic int cycles(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: return legal_r(f) ? 4 : 2;
      6'b001101, 6'b001111, 6'b101011: return 4;
      6'b100011: return 5;
      6'b000100: return 3;
      default:   return 2;
    endcase
  endfunction

  function automatic int pulses(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000100 || o == 6'b000010) return 0;
    if (cycles(o, f) == 2 && o != 6'b000011) return 0;
    return 1;
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is FETCH).
  function automatic logic [16:0] model(input logic [5:0] o, input logic [5:0] f,
                                        input logic z, input int k);
    logic pc, ir, rw, mw, src, ill;
    logic [1:0] ext, rd, wb, npc;
    logic [2:0] ctr;
    int n;
    {pc, ir, rw, mw, src, ill} = '0;
    {ext, rd, wb, npc, ctr} = '0;
    n = cycles(o, f);
    if (k == 0) begin
      pc = 1'b1;
      ir = 1'b1;
    end else begin
      case (o)
        6'b000000: if (legal_r(f)) begin
          rd  = 2'b01;
          ctr = (f == 6'b100011) ? 3'b001 : 3'b000;
        end
        6'b001101: begin src = 1'b1; ctr = 3'b010; end
        6'b001111: begin ext = 2'b10; src = 1'b1; end
        6'b100011, 6'b101011: begin ext = 2'b01; src = 1'b1; end
        6'b000100: begin ext = 2'b01; ctr = 3'b001; end
        6'b000011: rd = 2'b10;
        default: ;
      endcase
      if (n == 2) begin
        if (o == 6'b000010) begin pc = 1'b1; npc = 2'b10; end
        else if (o == 6'b000011) begin pc = 1'b1; npc = 2'b10; rw = 1'b1; wb = 2'b10; end
        else ill = 1'b1;
      end
      if (o == 6'b000100 && k == 2) begin pc = z; npc = 2'b01; end
      if (n >= 4 && k == n - 1) begin
        if (o == 6'b101011) mw = 1'b1;
        else rw = 1'b1;
        if (o == 6'b100011) wb = 2'b01;
      end
    end
    return {pc, ir, rw, mw, ext, src, ctr, rd, wb, npc, ill};
  endfunction

  // Called while the DUT is in FETCH (before that cycle's falling edge).
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
    int n;
    int cnt;
    n = cycles(o, f);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op = o;
        funct = f;
      end
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check($sformatf("op%b_fn%b_k%0d", o, f, k), 32'(obs), 32'(model(o, f, zero, k)));
      cnt += int'(reg_wr) + int'(mem_wr);
    end
    check($sformatf("pulses_op%b", o), 32'(cnt), 32'(pulses(o, f)));
  endtask

  logic [5:0] op_tab [9] = '{6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100,
                             6'b001111, 6'b000010, 6'b000011, 6'b000000};

  initial begin
    logic [5:0] o, f;
    int idx;

    @(negedge clk);
    #1 check("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_outputs", 32'(obs), 32'd0);

    run_instr(6'b100011, 6'd0, 2);
    run_instr(6'b001111, 6'd5, 2);
    run_instr(6'b001101, 6'd0, 2);
    run_instr(6'b000100, 6'd0, 1);
    run_instr(6'b000100, 6'd0, 0);
    run_instr(6'b000011, 6'd0, 2);
    run_instr(6'b111111, 6'd0, 2);
    run_instr(6'b000000, 6'b100001, 2);
    run_instr(6'b000000, 6'b100011, 2);
    run_instr(6'b000000, 6'b100000, 2);

    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(0, 10);
      f = 6'($urandom);
      if (idx == 9) o = 6'($urandom);
      else if (idx == 10) o = 6'b000000;
      else begin
        o = op_tab[idx];
        if (o == 6'b000000) f = $urandom_range(0, 1) ? 6'b100001 : 6'b100011;
      end
      run_instr(o, f, 2);
    end

    // sw abandoned by reset while in MEM_WR
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op = 6'b101011;
        funct = 6'd0;
      end
      #1 check($sformatf("sw_pre_reset_k%0d", k), 32'(obs), 32'(model(6'b101011, 6'd0, zero, k)));
    end
    check("sw_mem_wr_before_reset", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    #1 check("held_reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    #1 check("post_reset_init", 32'(obs), 32'd0);
    run_instr(6'b000010, 6'd0, 2);
    run_instr(6'b100011, 6'd0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
